// File: rtl/payout_pkg.sv
// Shared definitions for the payout BCD conversion slice.
//   state_t  : conversion sequencer states
//   BCD_NINE : value of a saturated BCD digit
//   pow10    : elaboration-time power of ten, used to size the display range
package payout_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      LATCH = 2'd2
   } state_t;

   localparam logic [3:0] BCD_NINE = 4'd9;

   function automatic longint unsigned pow10(input int unsigned n);
      longint unsigned r;
      r = 1;
      for (int unsigned i = 0; i < n; i++) begin
         r = r * 10;
      end
      return r;
   endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: a BCD digit of 5 or more gets +3 before the
// shift, so that doubling it carries correctly into the next decade.
//   digit    : current 4-bit BCD digit
//   adjusted : digit + 3 when digit >= 5, otherwise digit unchanged
module bcd_digit_adj (
   input  logic [3:0] digit,
   output logic [3:0] adjusted
);

   always_comb begin
      adjusted = digit;
      if (digit >= 4'd5) begin
         adjusted = digit + 4'd3;
      end
   end

endmodule

// File: rtl/payout_bcd_seq.sv
// Sequential binary-to-BCD converter for the payout display.
// Converts the winnings total into DIGITS packed BCD digits using one
// shift-add-3 step per clock, and reports winner / no-win / overflow flags.
//   clk       : rising-edge clock
//   reset     : asynchronous active-low reset
//   start     : request conversion of sum (honoured only when idle)
//   sum       : binary winnings total, captured on an accepted start
//   abort     : cancels any conversion and clears the flags (bcd holds)
//   busy      : conversion in progress
//   done      : one-cycle pulse when bcd and flags are updated
//   bcd       : packed BCD, units digit in bits [3:0]
//   winner    : last conversion had a nonzero sum
//   not_a_win : last conversion had a zero sum
//   overflow  : last conversion exceeded the displayable range
module payout_bcd_seq
   import payout_pkg::*;
#(
   parameter int SUM_W    = 14,
   parameter int DIGITS   = 4,
   parameter bit SATURATE = 1'b1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic [SUM_W-1:0]    sum,
   input  logic                abort,
   output logic                busy,
   output logic                done,
   output logic [4*DIGITS-1:0] bcd,
   output logic                winner,
   output logic                not_a_win,
   output logic                overflow
);

   localparam int                 BCD_W        = 4 * DIGITS;
   localparam int                 CNT_W        = $clog2(SUM_W + 1);
   localparam logic [63:0]        MAXV         = 64'(pow10(DIGITS) - 1);
   localparam logic [63:0]        SUM_MAX      = (64'd1 << SUM_W) - 64'd1;
   localparam bit                 OVF_POSSIBLE = (SUM_MAX > MAXV);
   localparam logic [BCD_W-1:0]   ALL_NINES    = {DIGITS{BCD_NINE}};

   state_t             state;
   logic [SUM_W-1:0]   bin;
   logic [BCD_W-1:0]   acc;
   logic [BCD_W-1:0]   adj;
   logic [CNT_W-1:0]   cnt;
   logic               ovf_cap;
   logic               zero_cap;
   logic               ovf_now;

   // When the input width cannot exceed the display range the compare is
   // dropped entirely rather than left to the synthesiser.
   generate
      if (OVF_POSSIBLE) begin : g_ovf
         assign ovf_now = (64'(sum) > MAXV);
      end else begin : g_no_ovf
         assign ovf_now = 1'b0;
      end
   endgenerate

   for (genvar g = 0; g < DIGITS; g++) begin : g_adj
      bcd_digit_adj u_adj (
         .digit    (acc[4*g +: 4]),
         .adjusted (adj[4*g +: 4])
      );
   end

   assign busy = (state != IDLE);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         bin       <= '0;
         acc       <= '0;
         cnt       <= '0;
         ovf_cap   <= 1'b0;
         zero_cap  <= 1'b0;
         bcd       <= '0;
         done      <= 1'b0;
         winner    <= 1'b0;
         not_a_win <= 1'b0;
         overflow  <= 1'b0;
      end else begin
         done <= 1'b0;
         if (abort) begin
            // bcd deliberately keeps the last displayed value
            state     <= IDLE;
            winner    <= 1'b0;
            not_a_win <= 1'b0;
            overflow  <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (start) begin
                     bin      <= sum;
                     acc      <= '0;
                     cnt      <= CNT_W'(SUM_W);
                     ovf_cap  <= ovf_now;
                     zero_cap <= (sum == '0);
                     // a zero total needs no shifting; acc is already 0
                     state    <= (sum == '0) ? LATCH : SHIFT;
                  end
               end
               SHIFT: begin
                  // bits leaving the top digit are dropped: result is mod 10^DIGITS
                  acc <= {adj[BCD_W-2:0], bin[SUM_W-1]};
                  bin <= {bin[SUM_W-2:0], 1'b0};
                  cnt <= cnt - CNT_W'(1);
                  if (cnt == CNT_W'(1)) begin
                     state <= LATCH;
                  end
               end
               LATCH: begin
                  bcd       <= (ovf_cap && SATURATE) ? ALL_NINES : acc;
                  winner    <= !zero_cap;
                  not_a_win <= zero_cap;
                  overflow  <= ovf_cap;
                  done      <= 1'b1;
                  state     <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_payout_bcd_seq.sv
module tb_payout_bcd_seq;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        abort;
   logic [13:0] sum;

   logic        busy, done, winner, not_a_win, overflow;
   logic [15:0] bcd;
   logic        busy_ns, done_ns, winner_ns, not_a_win_ns, overflow_ns;
   logic [15:0] bcd_ns;

   payout_bcd_seq #(.SUM_W(14), .DIGITS(4), .SATURATE(1'b1)) dut (
      .clk(clk), .reset(reset), .start(start), .sum(sum), .abort(abort),
      .busy(busy), .done(done), .bcd(bcd), .winner(winner),
      .not_a_win(not_a_win), .overflow(overflow)
   );

   payout_bcd_seq #(.SUM_W(14), .DIGITS(4), .SATURATE(1'b0)) dut_ns (
      .clk(clk), .reset(reset), .start(start), .sum(sum), .abort(abort),
      .busy(busy_ns), .done(done_ns), .bcd(bcd_ns), .winner(winner_ns),
      .not_a_win(not_a_win_ns), .overflow(overflow_ns)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [13:0] sum;
      logic [15:0] bcd_sat;
      logic [15:0] bcd_mod;
      logic        win;
      logic        nw;
      logic        ovf;
   } vec_t;

   vec_t sb[$];
   vec_t tbl[10];
   int   total = 0;
   int   bad = 0;
   int   done_count = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // scoreboard: every done pops the oldest expected conversion
   always @(negedge clk) begin
      vec_t e;
      if (reset === 1'b1 && (done || done_ns)) begin
         done_count++;
         if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_done: got done=%0b expected no done", done);
         end else begin
            e = sb.pop_front();
            check("done_pair", done_ns, done);
            check("bcd_sat", bcd, e.bcd_sat);
            check("winner", winner, e.win);
            check("not_a_win", not_a_win, e.nw);
            check("overflow", overflow, e.ovf);
            check("bcd_mod", bcd_ns, e.bcd_mod);
            check("overflow_mod", overflow_ns, e.ovf);
         end
      end
   end

   // Starts a conversion from a negedge and waits for done; edges counts
   // clock edges after the one that sampled start.
   task automatic do_conv(input vec_t v, output int edges, output int busy_lo);
      sb.push_back(v);
      sum   = v.sum;
      start = 1'b1;
      edges = -1;
      busy_lo = 0;
      for (int n = 1; n <= 60; n++) begin
         @(negedge clk);
         start = 1'b0;
         if (done) begin
            edges = n - 1;
            check("busy_at_done", busy, 1'b0);
            break;
         end
         if (!busy) busy_lo++;
      end
      if (edges < 0) begin
         check("done_timeout", 32'(edges), 32'd0);
         sb.delete();
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int edges, busy_lo, dc0;
      tbl[0] = '{14'd537,   16'h0537, 16'h0537, 1'b1, 1'b0, 1'b0};
      tbl[1] = '{14'd0,     16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0};
      tbl[2] = '{14'd12345, 16'h9999, 16'h2345, 1'b1, 1'b0, 1'b1};
      tbl[3] = '{14'd9999,  16'h9999, 16'h9999, 1'b1, 1'b0, 1'b0};
      tbl[4] = '{14'd10000, 16'h9999, 16'h0000, 1'b1, 1'b0, 1'b1};
      tbl[5] = '{14'd1,     16'h0001, 16'h0001, 1'b1, 1'b0, 1'b0};
      tbl[6] = '{14'd16383, 16'h9999, 16'h6383, 1'b1, 1'b0, 1'b1};
      tbl[7] = '{14'd81,    16'h0081, 16'h0081, 1'b1, 1'b0, 1'b0};
      tbl[8] = '{14'd5,     16'h0005, 16'h0005, 1'b1, 1'b0, 1'b0};
      tbl[9] = '{14'd1000,  16'h1000, 16'h1000, 1'b1, 1'b0, 1'b0};

      reset = 1'b1; start = 1'b0; abort = 1'b0; sum = '0;
      #2 reset = 1'b0;
      #1;
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_bcd", bcd, 16'h0000);
      check("rst_winner", winner, 1'b0);
      check("rst_not_a_win", not_a_win, 1'b0);
      check("rst_overflow", overflow, 1'b0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);

      // table-driven conversions
      for (int i = 0; i < 10; i++) begin
         do_conv(tbl[i], edges, busy_lo);
         if (tbl[i].sum == 14'd0)
            check("latency_zero", (edges >= 1 && edges <= 2), 1'b1);
         else
            check("latency", 32'(edges), 32'd15);
         check("busy_during", 32'(busy_lo), 32'd0);
         @(negedge clk);
      end
      repeat (3) @(negedge clk);
      check("bcd_hold", bcd, 16'h1000);

      // reset in the middle of a conversion
      sum = 14'd537; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (4) @(negedge clk);
      dc0 = done_count;
      reset = 1'b0;
      #1;
      check("midrst_busy", busy, 1'b0);
      check("midrst_bcd", bcd, 16'h0000);
      check("midrst_winner", winner, 1'b0);
      check("midrst_overflow", overflow, 1'b0);
      @(negedge clk);
      reset = 1'b1;
      repeat (20) @(negedge clk);
      check("midrst_no_done", 32'(done_count), 32'(dc0));

      // abort during a conversion
      do_conv(tbl[0], edges, busy_lo);
      check("pre_abort_latency", 32'(edges), 32'd15);
      @(negedge clk);
      sum = 14'd81; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      dc0 = done_count;
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("abort_busy", busy, 1'b0);
      check("abort_winner", winner, 1'b0);
      check("abort_not_a_win", not_a_win, 1'b0);
      check("abort_overflow", overflow, 1'b0);
      check("abort_bcd", bcd, 16'h0537);
      repeat (20) @(negedge clk);
      check("abort_no_done", 32'(done_count), 32'(dc0));

      // start and abort together: start dropped
      sum = 14'd81; start = 1'b1; abort = 1'b1;
      @(negedge clk);
      start = 1'b0; abort = 1'b0;
      check("start_abort_busy", busy, 1'b0);
      repeat (20) @(negedge clk);
      check("start_abort_no_done", 32'(done_count), 32'(dc0));
      check("start_abort_bcd", bcd, 16'h0537);

      // starts while busy are ignored; start in the done cycle is accepted
      sb.push_back(tbl[0]);
      sum = 14'd537; start = 1'b1;
      edges = -1;
      for (int n = 1; n <= 60; n++) begin
         @(negedge clk);
         start = 1'b0;
         if (done) begin
            edges = n - 1;
            break;
         end
         if (n == 3 || n == 7) begin
            sum = 14'd1; start = 1'b1;
         end
      end
      check("busy_start_latency", 32'(edges), 32'd15);
      do_conv(tbl[3], edges, busy_lo);
      check("b2b_latency", 32'(edges), 32'd15);
      check("b2b_busy", 32'(busy_lo), 32'd0);
      repeat (20) @(negedge clk);
      check("sb_empty", 32'(sb.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
